// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access unit (loads/stores over a req/ack bus).
// Latency: ALU/NOP ops pass through combinationally; loads/stores take IDLE+BUSY(n)+DONE cycles.
// Backpressure: stallreq holds upstream stages until the bus access completes or times out.
// Optional: define ALIGN_CHECK_EN to reject misaligned accesses and expose the misalign port.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
`ifdef ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  // Last counter value before the access is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic [31:0]       cap;
  logic              aborted;

  logic              is_load, is_store, is_mem;
  logic              sz_byte, sz_half, sz_word;
  logic              mis;
  logic              to_hit;
  logic [3:0]        sel_nxt;
  logic [31:0]       wdata_nxt;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;

  // Decode access class and size from the op code; unknown codes fall out as NOP.
  always_comb begin
    is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    is_mem   = is_load || is_store;
    sz_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
    sz_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
    sz_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
  end

`ifdef ALIGN_CHECK_EN
  assign mis      = (sz_half && mem_addr[0]) || (sz_word && (mem_addr[1:0] != 2'b00));
  assign misalign = !rst && (state == IDLE) && mis;
`else
  // Illegal low address bits are simply ignored by the lane logic below.
  assign mis = 1'b0;
`endif

  assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  // Big-endian lane select and lane-replicated store data for the request.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = mem_sdata;
    if (sz_byte) begin
      sel_nxt   = 4'b1000 >> mem_addr[1:0];
      wdata_nxt = {4{mem_sdata[7:0]}};
    end else if (sz_half) begin
      sel_nxt   = mem_addr[1] ? 4'b0011 : 4'b1100;
      wdata_nxt = {2{mem_sdata[15:0]}};
    end
  end

  // Extract and extend the loaded value from the captured bus word.
  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = cap[31:24];
      2'd1:    ld_byte = cap[23:16];
      2'd2:    ld_byte = cap[15:8];
      default: ld_byte = cap[7:0];
    endcase
    ld_half = mem_addr[1] ? cap[15:0] : cap[31:16];
    case (mem_op)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      default: ld_val = cap;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start on an accepted memory op, finish on ack or timeout, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_mem && !mis) state_nxt = BUSY;
      BUSY:    if (bus_ack || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pass-through in IDLE, bubble while stalled, final load/store result in DONE.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    stallreq = 1'b0;
    if (rst) begin
      wb_wd    = 5'd0;
      wb_wreg  = 1'b0;
      wb_wdata = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            wb_wreg  = 1'b0;
            stallreq = !mis;
          end
        end
        BUSY: begin
          wb_wreg  = 1'b0;
          stallreq = 1'b1;
        end
        DONE: begin
          if (is_load && !aborted) begin
            wb_wdata = ld_val;
          end else begin
            wb_wreg  = 1'b0;
          end
        end
        default: wb_wreg = 1'b0;
      endcase
    end
  end

  // Bus request registers, timeout counter, read capture and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      to_cnt    <= '0;
      cap       <= 32'd0;
      aborted   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (is_mem && !mis) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= sel_nxt;
            bus_wdata <= wdata_nxt;
            aborted   <= 1'b0;
          end
        end
        BUSY: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus_ack) begin
            cap     <= bus_rdata;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end else if (to_hit) begin
            cap     <= 32'd0;
            aborted <= 1'b1;
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
